// File: rtl/conv_stream.sv
// conv_stream: streams a wide input vector through one external crossbar tile,
// one TILE_ROWS-wide slice per cycle. Signed ADC partial sums are accumulated
// with saturation, optionally clamped by ReLU, and returned over valid/ready.
//
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   in_valid/in_ready, Input_feature, Address, relu_en - request handshake + payload
//   tile_en, tile_data, tile_addr - slice issued to the crossbar tile
//   tile_out       - signed tile result, TILE_LAT cycles after tile_en
//   out_valid/out_ready, Output, overflow - result handshake + payload
module conv_stream #(
   parameter int unsigned INPUT_SIZE = 128,
   parameter int unsigned TILE_ROWS  = 32,
   parameter int unsigned DEPTH      = 6,
   parameter int unsigned ADC_P      = 8,
   parameter int unsigned ACC_W      = 16,
   parameter int unsigned TILE_LAT   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [INPUT_SIZE-1:0] Input_feature,
   input  logic [DEPTH-1:0]      Address,
   input  logic                  relu_en,
   output logic                  tile_en,
   output logic [TILE_ROWS-1:0]  tile_data,
   output logic [DEPTH-1:0]      tile_addr,
   input  logic [ADC_P-1:0]      tile_out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_W-1:0]      Output,
   output logic                  overflow
);

   localparam int unsigned NSLICE = INPUT_SIZE / TILE_ROWS;
   localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam int unsigned EXT_W  = ACC_W + 1 - ADC_P;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t                 state, state_nxt;
   logic [CNT_W-1:0]       issue_cnt;
   logic [CNT_W-1:0]       ret_cnt;
   logic [TILE_LAT-1:0]    vld_sr;
   logic [INPUT_SIZE-1:0]  feat_q;
   logic                   relu_q;
   logic [ACC_W-1:0]       acc;

   logic                   accept_c;
   logic                   sample_c;
   logic                   last_issue_c;
   logic                   last_ret_c;
   logic [ACC_W:0]         sum_c;
   logic [ACC_W-1:0]       acc_nxt_c;
   logic                   sat_c;
   logic [ACC_W-1:0]       res_c;

   // Handshake / progress qualifiers
   always_comb begin
      accept_c     = (state == IDLE) && in_valid;
      sample_c     = vld_sr[TILE_LAT-1];
      last_issue_c = (issue_cnt == CNT_W'(NSLICE - 1));
      last_ret_c   = sample_c && (ret_cnt == CNT_W'(NSLICE - 1));
   end

   // Saturating accumulate: one guard bit detects overflow of the signed sum
   always_comb begin
      sum_c     = {acc[ACC_W-1], acc} + {{EXT_W{tile_out[ADC_P-1]}}, tile_out};
      sat_c     = 1'b0;
      acc_nxt_c = acc;
      if (sample_c) begin
         if (sum_c[ACC_W] != sum_c[ACC_W-1]) begin
            sat_c     = 1'b1;
            acc_nxt_c = sum_c[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
         end else begin
            acc_nxt_c = sum_c[ACC_W-1:0];
         end
      end
      res_c = (relu_q && acc_nxt_c[ACC_W-1]) ? '0 : acc_nxt_c;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)     state_nxt = ISSUE;
         ISSUE:   if (last_issue_c) state_nxt = DRAIN;
         DRAIN:   if (last_ret_c)   state_nxt = DONE;
         DONE:    if (out_ready)    state_nxt = IDLE;
         default:                   state_nxt = IDLE;
      endcase
   end

   // State register, datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         issue_cnt <= '0;
         ret_cnt   <= '0;
         vld_sr    <= '0;
         feat_q    <= '0;
         relu_q    <= 1'b0;
         acc       <= '0;
         overflow  <= 1'b0;
         in_ready  <= 1'b1;
         tile_en   <= 1'b0;
         tile_data <= '0;
         tile_addr <= '0;
         out_valid <= 1'b0;
         Output    <= '0;
      end else begin
         state     <= state_nxt;
         in_ready  <= (state_nxt == IDLE);
         out_valid <= (state_nxt == DONE);
         tile_en   <= (state_nxt == ISSUE);
         // Flags which cycles carry a valid tile_out
         vld_sr    <= TILE_LAT'({vld_sr, tile_en});

         if (accept_c) begin
            // Slice 0 goes out next cycle; the remainder is shifted down per issue
            tile_data <= Input_feature[TILE_ROWS-1:0];
            feat_q    <= Input_feature >> TILE_ROWS;
            tile_addr <= Address;
            relu_q    <= relu_en;
            acc       <= '0;
            overflow  <= 1'b0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
         end else begin
            if (state == ISSUE) begin
               issue_cnt <= issue_cnt + CNT_W'(1);
               tile_data <= last_issue_c ? '0 : feat_q[TILE_ROWS-1:0];
               feat_q    <= feat_q >> TILE_ROWS;
            end
            if (sample_c) begin
               acc     <= acc_nxt_c;
               ret_cnt <= ret_cnt + CNT_W'(1);
               if (sat_c) overflow <= 1'b1;
            end
            if (last_ret_c) Output <= res_c;
         end
      end
   end

endmodule

// File: tb/tb_conv_stream.sv
// Testbench for conv_stream: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from a behavioural accumulate/saturate model.
module tb_conv_stream;

   localparam int unsigned INPUT_SIZE = 128;
   localparam int unsigned TILE_ROWS  = 32;
   localparam int unsigned DEPTH      = 6;
   localparam int unsigned ADC_P      = 8;
   localparam int unsigned ACC_W      = 9;
   localparam int unsigned TILE_LAT   = 3;
   localparam int          NSLICE     = INPUT_SIZE / TILE_ROWS;
   localparam longint      MAXV       = (longint'(1) << (ACC_W - 1)) - 1;
   localparam longint      MINV       = -(longint'(1) << (ACC_W - 1));

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic [INPUT_SIZE-1:0] Input_feature = '0;
   logic [DEPTH-1:0]      Address = '0;
   logic                  relu_en = 1'b0;
   logic                  tile_en;
   logic [TILE_ROWS-1:0]  tile_data;
   logic [DEPTH-1:0]      tile_addr;
   logic [ADC_P-1:0]      tile_out;
   logic                  out_valid;
   logic                  out_ready = 1'b1;
   logic [ACC_W-1:0]      Output;
   logic                  overflow;

   conv_stream #(
      .INPUT_SIZE(INPUT_SIZE), .TILE_ROWS(TILE_ROWS), .DEPTH(DEPTH),
      .ADC_P(ADC_P), .ACC_W(ACC_W), .TILE_LAT(TILE_LAT)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .Input_feature(Input_feature), .Address(Address), .relu_en(relu_en),
      .tile_en(tile_en), .tile_data(tile_data), .tile_addr(tile_addr),
      .tile_out(tile_out), .out_valid(out_valid), .out_ready(out_ready),
      .Output(Output), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct { longint res; bit ov; int cyc; } exp_t;
   typedef struct { logic [TILE_ROWS-1:0] d; logic [DEPTH-1:0] a; } slc_t;

   exp_t eq[$];
   slc_t sq[$];
   int   vq[$];
   int   nerr = 0;
   int   nchk = 0;
   int   cyc  = 0;
   bit   busy = 1'b0;
   bit   hs_q = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: running sum clamped after every addition, then optional ReLU
   function automatic void model(input int v[NSLICE], input bit relu,
                                 output longint r, output bit ov);
      longint a = 0;
      ov = 1'b0;
      for (int i = 0; i < NSLICE; i++) begin
         a += v[i];
         if (a > MAXV) begin a = MAXV; ov = 1'b1; end
         else if (a < MINV) begin a = MINV; ov = 1'b1; end
      end
      r = (relu && a < 0) ? 0 : a;
   endfunction

   // Expected busy state: set by an accepted request, cleared after handshake
   always @(posedge clk) begin
      if (rst)                   busy <= 1'b0;
      else if (in_valid && !busy) busy <= 1'b1;
      else if (hs_q)             busy <= 1'b0;
   end

   // Tile model: return the queued value TILE_LAT cycles after each tile_en,
   // random junk in every other slot
   logic [ADC_P-1:0] pipe [TILE_LAT];
   logic [ADC_P-1:0] pend = '0;
   assign tile_out = pipe[TILE_LAT-1];

   always @(posedge clk) begin
      for (int i = TILE_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= pend;
   end

   always @(negedge clk) begin
      slc_t s;
      pend = ADC_P'($urandom);
      if (!rst) begin
         if (tile_en) begin
            if (sq.size() == 0) begin
               nchk++; nerr++;
               $display("FAIL tile_en_unexpected: got tile_en=1 expected 0 (cycle %0d)", cyc);
            end else begin
               s = sq.pop_front();
               chk("tile_data", longint'(tile_data), longint'(s.d));
               chk("tile_addr", longint'(tile_addr), longint'(s.a));
            end
            if (vq.size() != 0) pend = ADC_P'(vq.pop_front());
         end else begin
            chk("tile_data_idle", longint'(tile_data), 0);
         end
      end
   end

   // Result monitor: pops one expectation per result, checks hold while stalled
   exp_t cur;
   bit   holding = 1'b0;
   always @(negedge clk) begin
      hs_q = !rst && out_valid && out_ready;
      if (rst) begin
         holding = 1'b0;
      end else begin
         chk("in_ready", longint'(in_ready), longint'(!busy));
         if (out_valid) begin
            if (!holding) begin
               if (eq.size() == 0) begin
                  nchk++; nerr++;
                  $display("FAIL out_valid_unexpected: got out_valid=1 expected 0 (cycle %0d)", cyc);
               end else begin
                  cur = eq.pop_front();
                  holding = 1'b1;
                  chk("out_latency", longint'(cyc), longint'(cur.cyc));
               end
            end
            if (holding) begin
               chk("Output", longint'($signed(Output)), cur.res);
               chk("overflow", longint'(overflow), longint'(cur.ov));
            end
            if (out_ready) holding = 1'b0;
         end else if (holding) begin
            nchk++; nerr++;
            $display("FAIL out_valid_dropped: got out_valid=0 expected 1 (cycle %0d)", cyc);
            holding = 1'b0;
         end
      end
   end

   function automatic logic [INPUT_SIZE-1:0] rand_feat();
      logic [INPUT_SIZE-1:0] f;
      for (int i = 0; i < INPUT_SIZE / 32; i++) f[i*32 +: 32] = $urandom;
      return f;
   endfunction

   // Record an accepted request in the scoreboard queues
   task automatic push_req(input logic [INPUT_SIZE-1:0] f, input logic [DEPTH-1:0] a,
                           input bit relu, input int v[NSLICE]);
      longint r;
      bit     ov;
      model(v, relu, r, ov);
      eq.push_back('{r, ov, cyc + NSLICE + TILE_LAT + 1});
      for (int k = 0; k < NSLICE; k++) begin
         sq.push_back('{f[k*TILE_ROWS +: TILE_ROWS], a});
         vq.push_back(v[k]);
      end
   endtask

   // All stimulus runs one time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input bit relu, input int v[NSLICE]);
      logic [INPUT_SIZE-1:0] f;
      logic [DEPTH-1:0]      a;
      int n = 0;
      while (busy && n < 300) begin step(); n++; end
      if (busy) begin
         nchk++; nerr++;
         $display("FAIL wait_idle: got busy=1 expected 0 (cycle %0d)", cyc);
      end
      f = rand_feat();
      a = DEPTH'($urandom);
      in_valid = 1'b1; Input_feature = f; Address = a; relu_en = relu;
      push_req(f, a, relu, v);
      step();
      in_valid = 1'b0; Input_feature = rand_feat();
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1; in_valid = 1'b0;
      eq.delete(); sq.delete(); vq.delete();
      repeat (n) step();
      rst = 1'b0;
      chk("rst_in_ready",  longint'(in_ready), 1);
      chk("rst_tile_en",   longint'(tile_en), 0);
      chk("rst_tile_data", longint'(tile_data), 0);
      chk("rst_tile_addr", longint'(tile_addr), 0);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_Output",    longint'(Output), 0);
      chk("rst_overflow",  longint'(overflow), 0);
   endtask

   initial begin
      int v[NSLICE];
      int n;
      do_reset(3);

      // Mixed-sign sum
      v = '{10, -3, 7, -20};   do_req(1'b0, v);
      // Positive saturation, then a clean request clears overflow
      v = '{127, 127, 127, 127}; do_req(1'b0, v);
      v = '{1, 1, 1, 1};       do_req(1'b0, v);
      // Negative saturation
      v = '{-128, -128, -128, -128}; do_req(1'b0, v);
      // ReLU on and off
      v = '{-50, 10, 0, 0};    do_req(1'b1, v);
      v = '{-50, 10, 0, 0};    do_req(1'b0, v);
      v = '{30, 40, 0, 5};     do_req(1'b1, v);

      // Backpressure: result held for several cycles, in_valid pulses ignored
      v = '{100, -7, 55, 3};
      n = 0;
      while (busy && n < 300) begin step(); n++; end
      out_ready = 1'b0;
      do_req(1'b0, v);
      for (int i = 0; i < 14; i++) begin
         in_valid = busy ? 1'(($urandom % 2)) : 1'b0;
         Input_feature = rand_feat(); Address = DEPTH'($urandom); relu_en = 1'($urandom);
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;

      // Reset in the middle of slice issue, then a normal request
      n = 0;
      while (busy && n < 300) begin step(); n++; end
      v = '{20, 20, 20, 20};   do_req(1'b0, v);
      do_reset(1);
      v = '{-1, 2, -3, 4};     do_req(1'b0, v);

      // Randomized traffic with random backpressure and occasional resets
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset(int'($urandom_range(1, 2)));
         end else begin
            out_ready = ($urandom % 4) != 0;
            if ($urandom % 3 == 0) begin
               logic [INPUT_SIZE-1:0] f;
               logic [DEPTH-1:0]      a;
               bit                    r;
               f = rand_feat(); a = DEPTH'($urandom); r = 1'($urandom);
               for (int k = 0; k < NSLICE; k++) v[k] = int'($signed(ADC_P'($urandom)));
               in_valid = 1'b1; Input_feature = f; Address = a; relu_en = r;
               if (!busy) push_req(f, a, r, v);
            end else begin
               in_valid = 1'b0;
            end
            step();
         end
      end

      in_valid = 1'b0; out_ready = 1'b1;
      n = 0;
      while (busy && n < 300) begin step(); n++; end
      chk("drain_busy", longint'(busy), 0);
      repeat (10) step();
      chk("scoreboard_empty", longint'(eq.size()), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/conv_stream.md
# conv_stream

Time-multiplexed successor to the recursive PIM convolution tree. Instead of instantiating one crossbar tile per 32-row slice plus an adder tree, it streams an arbitrarily wide input vector through a single external crossbar tile, one slice per cycle. It accumulates the signed ADC partial sums in a wide saturating accumulator, optionally applies ReLU, and returns the result over a valid/ready handshake. It sits between the feature-fetch logic and the PIM tile.

## Interface
- INPUT_SIZE, 128: total input-vector width; must be a positive multiple of TILE_ROWS.
- TILE_ROWS, 32: rows of one crossbar tile, i.e. the slice width.
- DEPTH, 6: crossbar column-address width.
- ADC_P, 8: signed ADC result width returned by the tile.
- ACC_W, 16: signed accumulator/output width; ACC_W ≥ ADC_P.
- TILE_LAT, 1: cycles from tile_en to valid tile_out; ≥ 1.
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- Input_feature  in  INPUT_SIZE  input vector.
- Address  in  DEPTH  crossbar column address.
- relu_en  in  1  clamp negative result to 0 for this request.
- tile_en  out  1  slice issued to tile this cycle.
- tile_data  out  TILE_ROWS  current slice.
- tile_addr  out  DEPTH  captured Address.
- tile_out  in  ADC_P  signed tile result, valid TILE_LAT cycles after tile_en.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- Output  out  ACC_W  signed accumulated result.
- overflow  out  1  saturation occurred during this request.

## Operation
- NSLICE = INPUT_SIZE/TILE_ROWS. Slice k is Input_feature[(k+1)*TILE_ROWS-1 : k*TILE_ROWS]. Slices are issued k = 0 first.
- The FSM has four states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: in_ready=1. If in_valid is high:
  - capture Input_feature, Address and relu_en;
  - clear acc and overflow;
  - go to ISSUE.
- ISSUE: tile_en=1 with tile_data = slice issue_cnt, one slice per cycle. After slice NSLICE-1 is issued, go to DRAIN.
- DRAIN: wait until all NSLICE results have returned, tracked by a TILE_LAT-deep valid shift register fed by tile_en and a return counter. Then go to DONE.
- Accumulation: every returned tile_out is sign-extended to ACC_W and added to acc.
  - The sum saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Any saturation sets overflow, which stays set until the next accept.
- DONE: out_valid=1. Output = (relu_en && acc<0) ? 0 : acc. Output and overflow are held stable until out_ready is high, then go to IDLE.
- The tile_addr output holds the captured Address from accept until the next accept.
- tile_data is 0 whenever tile_en=0.
- in_valid outside IDLE is ignored; the request is not captured.
- tile_out is sampled only in cycles flagged by the valid shift register. Tile output at any other time is ignored.
- rst high in any state:
  - next cycle the state is IDLE;
  - counters, acc, overflow and the shift register are cleared;
  - the in-flight request is discarded and no out_valid is produced for it.

## Timing
- Reset values:
  - in_ready=1 (IDLE);
  - tile_en=0, tile_data=0, tile_addr=0;
  - out_valid=0, Output=0, overflow=0.
- Accept at cycle 0 (in_valid && in_ready).
- tile_en is high in cycles 1..NSLICE.
- The result for slice k arrives at cycle 1+k+TILE_LAT.
- out_valid first goes high at cycle NSLICE+TILE_LAT+1.
- Minimum request-to-request spacing is NSLICE+TILE_LAT+2 cycles, with out_ready held high.
- in_ready is low from cycle 1 until the cycle after the out_valid&&out_ready handshake.
- Throughput is one slice per cycle; there are no bubbles inside ISSUE.

## Test plan
- **Single slice** (INPUT_SIZE=32, TILE_LAT=1): request with tile_out=+5 → tile_en at cycle 1 only; out_valid at cycle 3 with Output=5, overflow=0.
- **Multi-slice sum** (INPUT_SIZE=128): tile returns +10, -3, +7, -20 → Output=-6. Check tile_data equals each slice in order 0..3 and tile_addr equals Address.
- **Saturation** (ACC_W=8, ADC_P=8, NSLICE=4): tile returns 127 each time → Output=127, overflow=1. Next request with tile returns 1,1,1,1 → Output=4, overflow=0.
- **ReLU:** returns -50, +10 with relu_en=1 → Output=0. The same request with relu_en=0 → Output=-40.
- **Backpressure:** hold out_ready=0 for 5 cycles in DONE → Output and overflow stable, in_ready=0, and in_valid pulses are ignored. Release → in_ready=1 on the following cycle.
- **Reset mid-ISSUE and TILE_LAT=3:**
  - assert rst at cycle 2 of a 4-slice request → no out_valid, all outputs at reset values next cycle;
  - the next request completes normally with out_valid at cycle NSLICE+4.
